// File: rtl/uart_alu_if_if.sv
// ---------------------------------------------------------------------------
// uart_alu_if_if : signal bundle between uart_alu_if and its surroundings
//                  (UART RX/TX FIFOs and the combinational ALU).
//
// RX FIFO : i_rx_empty, i_r_data (head word), o_rd_uart (pop strobe)
// TX FIFO : i_tx_full, o_wr_uart (push strobe), o_w_data (byte to push)
// ALU     : o_data_a, o_data_b, o_op (operands/opcode), i_alu_result
// Status  : o_frame_err (one-cycle pulse when a frame is aborted)
//
// master : the uart_alu_if side (drives the o_* signals)
// slave  : the environment side (FIFOs + ALU, drives the i_* signals)
// ---------------------------------------------------------------------------
interface uart_alu_if_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic               i_rx_empty;
  logic [NB_DATA-1:0] i_r_data;
  logic               o_rd_uart;
  logic               i_tx_full;
  logic               o_wr_uart;
  logic [NB_DATA-1:0] o_w_data;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_op;
  logic [NB_DATA-1:0] i_alu_result;
  logic               o_frame_err;

  modport master (
    input  i_rx_empty, i_r_data, i_tx_full, i_alu_result,
    output o_rd_uart, o_wr_uart, o_w_data, o_data_a, o_data_b, o_op, o_frame_err
  );

  modport slave (
    output i_rx_empty, i_r_data, i_tx_full, i_alu_result,
    input  o_rd_uart, o_wr_uart, o_w_data, o_data_a, o_data_b, o_op, o_frame_err
  );
endinterface

// File: rtl/uart_alu_if.sv
// ---------------------------------------------------------------------------
// uart_alu_if : frames UART bytes into ALU operations.
//   Pops operand A, operand B and opcode from the RX FIFO, holds them on the
//   ALU inputs, samples the ALU result one cycle later and pushes it into the
//   TX FIFO. An optional inter-byte timeout aborts incomplete frames.
//
// Ports:
//   i_clk   : system clock
//   i_reset : synchronous, active-high reset
//   bus     : uart_alu_if_if.master (RX FIFO, TX FIFO, ALU and error pulse)
//
// Parameters:
//   NB_DATA    : operand/result/UART byte width
//   NB_OP      : opcode width (low NB_OP bits of the third byte)
//   TIMEOUT    : max idle cycles between bytes of one frame, 0 = disabled
//   NB_TIMEOUT : timeout counter width
// ---------------------------------------------------------------------------
module uart_alu_if #(
  parameter int NB_DATA    = 8,
  parameter int NB_OP      = 6,
  parameter int TIMEOUT    = 0,
  parameter int NB_TIMEOUT = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  uart_alu_if_if.master        bus
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_CALC = 3'd3,
    S_SEND = 3'd4
  } state_t;

  localparam logic                  TO_EN   = (TIMEOUT != 0);
  // With TIMEOUT=0 this wraps to all ones, but TO_EN gates every use.
  localparam logic [NB_TIMEOUT-1:0] TO_LAST = NB_TIMEOUT'(TIMEOUT - 1);

  state_t                state_r;
  state_t                state_next_s;
  logic                  rd_s;
  logic                  wr_s;
  logic                  expire_s;
  logic                  cnt_last_s;
  logic [NB_DATA-1:0]    data_a_r;
  logic [NB_DATA-1:0]    data_b_r;
  logic [NB_OP-1:0]      op_r;
  logic [NB_DATA-1:0]    result_r;
  logic                  frame_err_r;
  logic [NB_TIMEOUT-1:0] cnt_r;

  assign cnt_last_s = TO_EN && (cnt_r == TO_LAST);

  // Next-state logic plus the combinational pop/push strobes and abort detect.
  always_comb begin
    state_next_s = state_r;
    rd_s         = 1'b0;
    wr_s         = 1'b0;
    expire_s     = 1'b0;
    case (state_r)
      S_A: begin
        rd_s = ~bus.i_rx_empty & ~i_reset;
        if (rd_s) begin
          state_next_s = S_B;
        end else begin
          state_next_s = S_A;
        end
      end
      S_B: begin
        rd_s = ~bus.i_rx_empty & ~i_reset;
        // An accept on the expiry edge wins over the abort.
        if (rd_s) begin
          state_next_s = S_OP;
        end else if (cnt_last_s) begin
          expire_s     = 1'b1;
          state_next_s = S_A;
        end else begin
          state_next_s = S_B;
        end
      end
      S_OP: begin
        rd_s = ~bus.i_rx_empty & ~i_reset;
        if (rd_s) begin
          state_next_s = S_CALC;
        end else if (cnt_last_s) begin
          expire_s     = 1'b1;
          state_next_s = S_A;
        end else begin
          state_next_s = S_OP;
        end
      end
      S_CALC: begin
        state_next_s = S_SEND;
      end
      S_SEND: begin
        // No timeout here: a full TX FIFO may stall the frame indefinitely.
        wr_s = ~bus.i_tx_full & ~i_reset;
        if (wr_s) begin
          state_next_s = S_A;
        end else begin
          state_next_s = S_SEND;
        end
      end
      default: begin
        state_next_s = S_A;
      end
    endcase
  end

  // State, captured operands/opcode/result, timeout counter and error pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r     <= S_A;
      data_a_r    <= '0;
      data_b_r    <= '0;
      op_r        <= '0;
      result_r    <= '0;
      frame_err_r <= 1'b0;
      cnt_r       <= '0;
    end else begin
      state_r     <= state_next_s;
      frame_err_r <= expire_s;
      if (rd_s && (state_r == S_A)) begin
        data_a_r <= bus.i_r_data;
      end
      if (rd_s && (state_r == S_B)) begin
        data_b_r <= bus.i_r_data;
      end
      if (rd_s && (state_r == S_OP)) begin
        op_r <= bus.i_r_data[NB_OP-1:0];
      end
      if (state_r == S_CALC) begin
        result_r <= bus.i_alu_result;
      end
      // Counts only idle cycles while waiting for B or the opcode.
      if (!TO_EN || rd_s || expire_s || !((state_r == S_B) || (state_r == S_OP))) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + NB_TIMEOUT'(1);
      end
    end
  end

  assign bus.o_rd_uart   = rd_s;
  assign bus.o_wr_uart   = wr_s;
  assign bus.o_w_data    = result_r;
  assign bus.o_data_a    = data_a_r;
  assign bus.o_data_b    = data_b_r;
  assign bus.o_op        = op_r;
  assign bus.o_frame_err = frame_err_r;

endmodule

// File: tb/tb_uart_alu_if.sv
// ---------------------------------------------------------------------------
// tb_uart_alu_if : self-checking bench for uart_alu_if (TIMEOUT=16).
//   Models the RX FIFO as a byte queue, the ALU as a function of the DUT's
//   operand outputs, and checks pushed bytes / error pulses against a
//   scoreboard filled at stimulus time from a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_uart_alu_if;
  localparam int NB_DATA    = 8;
  localparam int NB_OP      = 6;
  localparam int TIMEOUT    = 16;
  localparam int NB_TIMEOUT = 32;

  typedef struct packed {
    logic       is_err;
    logic [7:0] val;
  } exp_t;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clk = ~i_clk;

  uart_alu_if_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

  uart_alu_if #(
    .NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT(TIMEOUT), .NB_TIMEOUT(NB_TIMEOUT)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .bus(bus)
  );

  int   checks     = 0;
  int   failures   = 0;
  int   cyc        = 0;
  int   pop_count  = 0;
  int   err_count  = 0;
  int   err_cyc    = 0;
  bit   pop_pend   = 1'b0;
  bit   rand_bp    = 1'b0;
  logic [7:0] rx_q[$];
  exp_t       exp_q[$];
  int         pop_cyc_q[$];
  int         push_cyc_q[$];

  // Reference ALU: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, else A.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   return 8'(a + b);
      6'h22:   return 8'(a - b);
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return a;
    endcase
  endfunction

  always_comb bus.i_alu_result = alu_ref(bus.o_data_a, bus.o_data_b, bus.o_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_q.push_back(b);
    bus.i_rx_empty = 1'b0;
    bus.i_r_data   = rx_q[0];
  endtask

  // Expected response of a complete frame, from the byte values alone.
  task automatic expect_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    exp_t e;
    e.is_err = 1'b0;
    e.val    = alu_ref(a, b, op[5:0]);
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.val    = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((rx_q.size() != 0 || exp_q.size() != 0) && n < 600) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 600) begin
      checks++;
      failures++;
      $display("FAIL %s_idle_timeout actual=pending required=drained", name);
    end
    repeat (3) @(negedge i_clk);
    #1;
  endtask

  task automatic wait_pops(input string name, input int k);
    int p0;
    int n;
    p0 = pop_count;
    n  = 0;
    while (pop_count < p0 + k && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL %s_pop_timeout actual=%0d required=%0d", name, pop_count - p0, k);
    end
  endtask

  // Edge monitor: values seen here are the pre-edge ones, i.e. what the DUT acts on.
  initial forever begin
    @(posedge i_clk);
    cyc++;
    if (bus.o_rd_uart === 1'b1) begin
      pop_pend = 1'b1;
      pop_count++;
      pop_cyc_q.push_back(cyc);
    end
    if (bus.o_wr_uart === 1'b1) begin
      push_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("tx_unexpected_push", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("tx_kind_is_err", 32'(e.is_err), 32'd0);
        check("tx_data", 32'(bus.o_w_data), 32'(e.val));
      end
    end
  end

  // Negedge: apply FIFO pops to the RX model and watch the error pulse.
  initial forever begin
    @(negedge i_clk);
    if (pop_pend) begin
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      pop_pend = 1'b0;
    end
    bus.i_rx_empty = (rx_q.size() == 0);
    bus.i_r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    if (bus.o_frame_err === 1'b1) begin
      err_cyc = cyc;
      err_count++;
      if (exp_q.size() == 0) begin
        check("err_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("err_kind_is_err", 32'(e.is_err), 32'd1);
      end
    end
  end

  // Random TX backpressure, only while enabled.
  initial forever begin
    @(negedge i_clk);
    if (rand_bp) bus.i_tx_full = ($urandom_range(0, 3) == 0);
  end

  initial begin
    int n0, e0, pa;
    logic [7:0] a, b, op;
    bus.i_rx_empty = 1'b1;
    bus.i_r_data   = 8'h00;
    bus.i_tx_full  = 1'b0;

    // Reset with a non-empty RX FIFO.
    push_rx(8'hAA);
    repeat (3) begin
      @(negedge i_clk);
      check("rst_rd_uart", 32'(bus.o_rd_uart), 32'd0);
      check("rst_wr_uart", 32'(bus.o_wr_uart), 32'd0);
      check("rst_data_a", 32'(bus.o_data_a), 32'd0);
      check("rst_data_b", 32'(bus.o_data_b), 32'd0);
      check("rst_op", 32'(bus.o_op), 32'd0);
      check("rst_w_data", 32'(bus.o_w_data), 32'd0);
      check("rst_frame_err", 32'(bus.o_frame_err), 32'd0);
    end
    rx_q.delete();
    bus.i_rx_empty = 1'b1;
    i_reset = 1'b0;
    @(negedge i_clk);
    #1;

    // Basic frame 5 + 3.
    pop_cyc_q.delete();
    push_cyc_q.delete();
    expect_frame(8'h05, 8'h03, 8'h20);
    push_rx(8'h05); push_rx(8'h03); push_rx(8'h20);
    wait_idle("basic");
    check("basic_pops", 32'(pop_cyc_q.size()), 32'd3);
    check("basic_pushes", 32'(push_cyc_q.size()), 32'd1);
    if (pop_cyc_q.size() == 3 && push_cyc_q.size() == 1) begin
      check("basic_pop_consec", 32'(pop_cyc_q[2] - pop_cyc_q[0]), 32'd2);
      check("basic_push_latency", 32'(push_cyc_q[0] - pop_cyc_q[2]), 32'd2);
    end
    check("basic_op", 32'(bus.o_op), 32'h20);

    // Opcode truncation and TX backpressure.
    bus.i_tx_full = 1'b1;
    n0 = push_cyc_q.size();
    expect_frame(8'h09, 8'h04, 8'hE2);
    push_rx(8'h09); push_rx(8'h04); push_rx(8'hE2);
    wait_pops("bp", 3);
    @(negedge i_clk);
    check("trunc_op", 32'(bus.o_op), 32'h22);
    repeat (10) begin
      @(negedge i_clk);
      check("bp_no_push", 32'(bus.o_wr_uart), 32'd0);
      check("bp_w_data", 32'(bus.o_w_data), 32'h05);
    end
    bus.i_tx_full = 1'b0;
    wait_idle("bp");
    check("bp_one_push", 32'(push_cyc_q.size() - n0), 32'd1);

    // Timeout: a lone A byte aborts 16 cycles after its accept.
    pop_cyc_q.delete();
    e0 = err_count;
    expect_err();
    push_rx(8'h11);
    wait_pops("to", 1);
    wait_idle("to");
    check("to_err_count", 32'(err_count - e0), 32'd1);
    if (pop_cyc_q.size() == 1) check("to_err_delay", 32'(err_cyc - pop_cyc_q[0]), 32'd16);
    check("to_keep_a", 32'(bus.o_data_a), 32'h11);
    check("to_keep_b", 32'(bus.o_data_b), 32'h04);
    check("to_keep_op", 32'(bus.o_op), 32'h22);
    expect_frame(8'h02, 8'h02, 8'h20);
    push_rx(8'h02); push_rx(8'h02); push_rx(8'h20);
    wait_idle("after_to");
    check("after_to_w_data", 32'(bus.o_w_data), 32'h04);

    // Byte arriving on the expiry edge is accepted without error.
    pop_cyc_q.delete();
    e0 = err_count;
    expect_frame(8'h30, 8'h40, 8'h20);
    push_rx(8'h30);
    wait_pops("exp_edge", 1);
    repeat (15) @(negedge i_clk);
    #1;
    push_rx(8'h40); push_rx(8'h20);
    wait_idle("exp_edge");
    check("exp_edge_no_err", 32'(err_count - e0), 32'd0);
    if (pop_cyc_q.size() >= 2) check("exp_edge_b_at", 32'(pop_cyc_q[1] - pop_cyc_q[0]), 32'd16);

    // Back-to-back frames from a preloaded FIFO.
    pop_cyc_q.delete();
    push_cyc_q.delete();
    expect_frame(8'h01, 8'h01, 8'h20);
    expect_frame(8'h07, 8'h02, 8'h22);
    push_rx(8'h01); push_rx(8'h01); push_rx(8'h20);
    push_rx(8'h07); push_rx(8'h02); push_rx(8'h22);
    wait_idle("b2b");
    check("b2b_pops", 32'(pop_cyc_q.size()), 32'd6);
    if (pop_cyc_q.size() == 6) begin
      check("b2b_f0_consec", 32'(pop_cyc_q[2] - pop_cyc_q[0]), 32'd2);
      check("b2b_period", 32'(pop_cyc_q[3] - pop_cyc_q[2]), 32'd3);
      check("b2b_f1_consec", 32'(pop_cyc_q[5] - pop_cyc_q[3]), 32'd2);
    end

    // Reset mid-frame after A and B.
    n0 = push_cyc_q.size();
    push_rx(8'h0A); push_rx(8'h0B);
    wait_pops("midrst", 2);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    check("midrst_a", 32'(bus.o_data_a), 32'd0);
    check("midrst_b", 32'(bus.o_data_b), 32'd0);
    check("midrst_op", 32'(bus.o_op), 32'd0);
    check("midrst_w_data", 32'(bus.o_w_data), 32'd0);
    #1;
    expect_frame(8'h06, 8'h07, 8'h26);
    push_rx(8'h06); push_rx(8'h07); push_rx(8'h26);
    wait_idle("midrst");
    check("midrst_pushes", 32'(push_cyc_q.size() - n0), 32'd1);

    // Random frames with small gaps, random backpressure and a few aborts.
    rand_bp = 1'b1;
    for (int f = 0; f < 40; f++) begin
      if (f % 8 == 7) begin
        wait_idle("rnd_pre_abort");
        expect_err();
        push_rx(8'($urandom));
        if ($urandom_range(0, 1) == 1) push_rx(8'($urandom));
        wait_idle("rnd_abort");
      end else begin
        a  = 8'($urandom);
        b  = 8'($urandom);
        case ($urandom_range(0, 6))
          0: op = 8'h20;
          1: op = 8'h22;
          2: op = 8'h24;
          3: op = 8'h25;
          4: op = 8'h26;
          5: op = 8'h27;
          default: op = 8'($urandom);
        endcase
        op[7:6] = 2'($urandom);
        expect_frame(a, b, op);
        push_rx(a);
        repeat ($urandom_range(0, 4)) @(negedge i_clk);
        #1;
        push_rx(b);
        repeat ($urandom_range(0, 4)) @(negedge i_clk);
        #1;
        push_rx(op);
      end
    end
    wait_idle("rnd_end");
    rand_bp = 1'b0;
    bus.i_tx_full = 1'b0;
    repeat (5) @(negedge i_clk);
    check("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
